// File: rtl/axi_apb_pkg.sv
// Shared definitions for the AXI-lite to APB3 bridge: FSM encoding,
// arbitration tags and address-decode constants.
package axi_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RRESP,
        ST_BRESP
    } state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    localparam logic [31:0] DECODE_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          SLOT_LSB        = 12;
    localparam int          SLOT_WIDTH      = 2;

    function automatic logic [SLOT_WIDTH-1:0] addr_slot(input logic [31:0] addr);
        return addr[SLOT_LSB +: SLOT_WIDTH];
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS-phase cycles and flags when a slave has kept the bus
// waiting for TIMEOUT_CYCLES cycles without PREADY.
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count;

    // Saturates at the limit so a late PREADY cannot wrap the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/axi_apb_bridge.sv
// Single-outstanding AXI-lite slave port to APB3 master bridge with
// read/write arbitration, slot decode, and timeout/decode-error recovery.
module axi_apb_bridge #(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [31:0]             s_rdata,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    input  logic [31:0]             s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [31:0]             s_wdata,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [31:0]             paddr,
    output logic [NUM_SLAVES-1:0]   psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [31:0]             pwdata,
    input  logic [32*NUM_SLAVES-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]   pready,
    input  logic [NUM_SLAVES-1:0]   pslverr,
    output logic                    err_pulse,
    output logic [31:0]             err_addr
);

    import axi_apb_pkg::*;

    state_t                state;
    state_t                state_nxt;
    grant_t                last_grant;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic                  write_q;
    logic [SLOT_WIDTH-1:0] slot_q;

    logic                  wr_cand;
    logic                  rd_cand;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  hs_any;
    logic [31:0]           hs_addr;
    logic [SLOT_WIDTH-1:0] hs_slot;
    logic                  hs_decode_err;

    logic                  sel_ready;
    logic                  sel_err;
    logic [31:0]           sel_rdata;
    logic                  in_access;
    logic                  tmo_expired;

    assign in_access = (state == ST_ACCESS);

    // A write needs both AW and W; on a tie the side not served last wins.
    always_comb begin
        wr_cand       = s_awvalid && s_wvalid;
        rd_cand       = s_arvalid;
        grant_wr      = (state == ST_IDLE) && wr_cand &&
                        (!rd_cand || (last_grant == GRANT_READ));
        grant_rd      = (state == ST_IDLE) && rd_cand && !grant_wr;
        hs_any        = grant_wr || grant_rd;
        hs_addr       = grant_wr ? s_awaddr : s_araddr;
        hs_slot       = addr_slot(hs_addr);
        hs_decode_err = (int'(hs_slot) >= NUM_SLAVES);
    end

    assign s_arready = grant_rd;
    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slot_q == i[SLOT_WIDTH-1:0]) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        psel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            psel[i] = ((state == ST_SETUP) || in_access) &&
                      (slot_q == i[SLOT_WIDTH-1:0]);
        end
    end

    assign penable  = in_access;
    assign s_rvalid = (state == ST_RRESP);
    assign s_bvalid = (state == ST_BRESP);
    assign paddr    = addr_q;
    assign pwdata   = wdata_q;
    assign pwrite   = write_q;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_access),
        .enable  (in_access),
        .expired (tmo_expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (hs_any) begin
                    if (hs_decode_err) begin
                        state_nxt = grant_wr ? ST_BRESP : ST_RRESP;
                    end else begin
                        state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready || tmo_expired) begin
                    state_nxt = write_q ? ST_BRESP : ST_RRESP;
                end
            end
            ST_RRESP: begin
                if (s_rready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BRESP: begin
                if (s_bready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Every error source loads err_addr and raises err_pulse on the edge
    // that enters the response state, so the pulse lines up with its valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            slot_q     <= '0;
            s_rdata    <= '0;
            err_pulse  <= 1'b0;
            err_addr   <= '0;
        end else begin
            state     <= state_nxt;
            err_pulse <= 1'b0;

            if (hs_any) begin
                addr_q     <= hs_addr;
                slot_q     <= hs_slot;
                write_q    <= grant_wr;
                last_grant <= grant_wr ? GRANT_WRITE : GRANT_READ;
                if (grant_wr) begin
                    wdata_q <= s_wdata;
                end
                if (hs_decode_err) begin
                    err_pulse <= 1'b1;
                    err_addr  <= hs_addr;
                    if (grant_rd) begin
                        s_rdata <= DECODE_ERR_DATA;
                    end
                end
            end

            if (in_access) begin
                if (sel_ready) begin
                    if (!write_q) begin
                        s_rdata <= sel_rdata;
                    end
                    if (sel_err) begin
                        err_pulse <= 1'b1;
                        err_addr  <= addr_q;
                    end
                end else if (tmo_expired) begin
                    err_pulse <= 1'b1;
                    err_addr  <= addr_q;
                    if (!write_q) begin
                        s_rdata <= DECODE_ERR_DATA;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_apb_bridge.sv
// Self-checking bench for axi_apb_bridge: behavioural APB slaves plus a
// transaction-level reference model of latency, data and error reporting.
module tb_axi_apb_bridge;

    localparam int          NSL  = 3;
    localparam int          TMO  = 8;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic              s_rvalid;
    logic              s_rready;
    logic [31:0]       s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [31:0]       s_wdata;
    logic              s_wvalid;
    logic              s_wready;
    logic              s_bvalid;
    logic              s_bready;
    logic [31:0]       paddr;
    logic [NSL-1:0]    psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [32*NSL-1:0] prdata;
    logic [NSL-1:0]    pready;
    logic [NSL-1:0]    pslverr;
    logic              err_pulse;
    logic [31:0]       err_addr;

    always #5 clk = ~clk;

    axi_apb_bridge #(
        .NUM_SLAVES     (NSL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .err_pulse (err_pulse),
        .err_addr  (err_addr)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] slv_mem [NSL][16];
    logic [31:0] mem_ref [NSL][16];
    logic [31:0] last_err_addr;
    int          cur_wait = 0;
    logic        cur_err  = 1'b0;
    logic        cur_hang = 1'b0;
    int          acc_cnt  = 0;

    logic [NSL-1:0] psel_or;
    int             setup_cnt;
    logic           mon_started;
    logic           hold_bad;
    logic [31:0]    paddr_first;
    logic [31:0]    pwdata_first;
    logic           pwrite_first;

    // APB slaves: selected slave answers after cur_wait ACCESS cycles unless
    // hung; unselected lanes carry random noise.
    always @(negedge clk) begin
        pready  = NSL'($urandom);
        pslverr = NSL'($urandom);
        prdata  = {$urandom, $urandom, $urandom};
        if (psel != 0 && penable) begin
            for (int i = 0; i < NSL; i++) begin
                if (psel[i]) begin
                    pready[i]  = 1'b0;
                    pslverr[i] = 1'b0;
                    if (!cur_hang && acc_cnt >= cur_wait) begin
                        pready[i]            = 1'b1;
                        pslverr[i]           = cur_err;
                        prdata[32*i +: 32]   = slv_mem[i][paddr[5:2]];
                        if (pwrite && !cur_err) slv_mem[i][paddr[5:2]] = pwdata;
                    end
                end
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (psel != 0) begin
            psel_or = psel_or | psel;
            if (!penable) setup_cnt++;
            if (!mon_started) begin
                paddr_first  = paddr;
                pwdata_first = pwdata;
                pwrite_first = pwrite;
                mon_started  = 1'b1;
            end else if (paddr !== paddr_first || pwdata !== pwdata_first ||
                         pwrite !== pwrite_first) begin
                hold_bad = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic is_wr, input logic [31:0] addr,
                                 input logic [31:0] data, output logic ok);
        ok = 1'b0;
        if (is_wr) begin
            s_awaddr  = addr;
            s_wdata   = data;
            s_awvalid = 1'b1;
            s_wvalid  = 1'b1;
        end else begin
            s_araddr  = addr;
            s_arvalid = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            #1;
            if ((is_wr && s_awready && s_wready) || (!is_wr && s_arready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end else begin
            checkOutput("handshake", 32'(is_wr ? s_awready : s_arready), 32'd1);
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
    endtask

    task automatic wait_resp(input logic is_wr, input int hold, input logic [31:0] exp_rd,
                             output int lat, output logic [31:0] rd, output logic errp);
        int cyc = 1;
        lat  = -1;
        rd   = '0;
        errp = 1'b0;
        while (cyc <= 40) begin
            if ((is_wr ? s_bvalid : s_rvalid) === 1'b1) begin
                lat = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (lat < 0) begin
            checkOutput("resp_valid", 32'(is_wr ? s_bvalid : s_rvalid), 32'd1);
            return;
        end
        rd   = s_rdata;
        errp = err_pulse;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checkOutput("resp_hold_valid", 32'(is_wr ? s_bvalid : s_rvalid), 32'd1);
            checkOutput("err_pulse_single", 32'(err_pulse), 32'd0);
            if (!is_wr) checkOutput("rdata_stable", s_rdata, exp_rd);
        end
        if (is_wr) s_bready = 1'b1;
        else       s_rready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        s_rready = 1'b0;
        checkOutput("resp_done", 32'({s_rvalid, s_bvalid}), 32'd0);
    endtask

    task automatic run_txn(input logic is_wr, input int slot, input int idx,
                           input logic [31:0] data, input int wt, input logic err,
                           input logic hang, input int hold);
        logic [31:0]    addr;
        logic [31:0]    exp_rd;
        logic [31:0]    rd;
        int             exp_lat;
        int             lat;
        logic           exp_err;
        logic           errp;
        logic           ok;
        logic           mapped;
        logic [NSL-1:0] exp_psel;
        addr     = BASE | (32'(slot) << 12) | (32'(idx) << 2);
        mapped   = (slot < NSL);
        cur_wait = wt;
        cur_err  = err;
        cur_hang = hang;
        psel_or     = '0;
        setup_cnt   = 0;
        mon_started = 1'b0;
        hold_bad    = 1'b0;
        if (!mapped) begin
            exp_lat = 1;   exp_rd = DEAD; exp_err = 1'b1; exp_psel = '0;
        end else if (hang) begin
            exp_lat = TMO + 3; exp_rd = DEAD; exp_err = 1'b1; exp_psel = NSL'(1 << slot);
        end else begin
            exp_lat = 3 + wt; exp_rd = mem_ref[slot][idx]; exp_err = err;
            exp_psel = NSL'(1 << slot);
        end
        if (exp_err) last_err_addr = addr;
        applyStimulus(is_wr, addr, data, ok);
        if (!ok) return;
        wait_resp(is_wr, hold, exp_rd, lat, rd, errp);
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("err_pulse", 32'(errp), 32'(exp_err));
        if (!is_wr) checkOutput("rdata", rd, exp_rd);
        checkOutput("err_addr", err_addr, last_err_addr);
        checkOutput("psel", 32'(psel_or), 32'(exp_psel));
        if (mapped) begin
            checkOutput("setup_cycles", 32'(setup_cnt), 32'd1);
            checkOutput("apb_hold", 32'(hold_bad), 32'd0);
            checkOutput("paddr", paddr_first, addr);
            checkOutput("pwrite", 32'(pwrite_first), 32'(is_wr));
            if (is_wr) checkOutput("pwdata", pwdata_first, data);
        end
        if (mapped && !hang && is_wr && !err) mem_ref[slot][idx] = data;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] rd;
        logic [31:0] wd1;
        logic [31:0] wd2;
        logic        errp;
        logic        ok;
        logic        rv;
        int          lat;

        rst = 1'b1;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        last_err_addr = '0;
        for (int i = 0; i < NSL; i++) begin
            for (int j = 0; j < 16; j++) begin
                v = $urandom;
                slv_mem[i][j] = v;
                mem_ref[i][j] = v;
            end
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset state");
        checkOutput("reset_rdata", s_rdata, 32'd0);
        checkOutput("reset_paddr", paddr, 32'd0);
        checkOutput("reset_pwdata", pwdata, 32'd0);
        checkOutput("reset_err_addr", err_addr, 32'd0);
        checkOutput("reset_ctrl", 32'({psel, penable, pwrite, s_rvalid, s_bvalid, err_pulse,
                                        s_arready, s_awready, s_wready}), 32'd0);

        $display("[TB] directed transactions");
        slv_mem[1][1] = 32'h1234_5678;
        mem_ref[1][1] = 32'h1234_5678;
        run_txn(1'b0, 1, 1, 32'd0, 0, 1'b0, 1'b0, 1);
        run_txn(1'b1, 2, 2, 32'hA5A5_A5A5, 3, 1'b0, 1'b0, 0);
        run_txn(1'b0, 2, 2, 32'd0, 1, 1'b0, 1'b0, 0);
        run_txn(1'b0, 3, 0, 32'd0, 0, 1'b0, 1'b0, 1);
        run_txn(1'b0, 0, 0, 32'd0, 0, 1'b0, 1'b1, 0);
        run_txn(1'b1, 1, 5, 32'hCAFE_0001, 0, 1'b1, 1'b0, 1);
        run_txn(1'b0, 2, 3, 32'd0, 2, 1'b1, 1'b0, 0);
        run_txn(1'b1, 3, 7, 32'h0BAD_0BAD, 0, 1'b0, 1'b0, 2);

        $display("[TB] random transactions");
        for (int n = 0; n < 30; n++) begin
            run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 2)));
        end

        $display("[TB] reset during access");
        cur_hang = 1'b1;
        applyStimulus(1'b0, BASE | 32'h0000_0010, 32'd0, ok);
        @(negedge clk);
        checkOutput("rst_pre_penable", 32'(penable), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_psel", 32'(psel), 32'd0);
        checkOutput("rst_penable", 32'(penable), 32'd0);
        rst = 1'b0;
        last_err_addr = '0;
        checkOutput("rst_rdata", s_rdata, 32'd0);
        checkOutput("rst_err_addr", err_addr, 32'd0);
        rv = 1'b0;
        repeat (12) begin
            @(negedge clk);
            rv = rv | s_rvalid;
        end
        checkOutput("rst_no_rvalid", 32'(rv), 32'd0);
        cur_hang = 1'b0;
        cur_wait = 0;
        cur_err  = 1'b0;

        $display("[TB] arbitration after reset");
        wd1 = $urandom;
        wd2 = $urandom;
        s_araddr  = BASE | 32'h0000_1008; s_arvalid = 1'b1;
        s_awaddr  = BASE | 32'h0000_2010; s_wdata = wd1;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        checkOutput("arb1_awready", 32'(s_awready && s_wready), 32'd1);
        checkOutput("arb1_arready", 32'(s_arready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        #1;
        checkOutput("arb_busy_arready", 32'(s_arready), 32'd0);
        wait_resp(1'b1, 0, 32'd0, lat, rd, errp);
        checkOutput("arb1_latency", 32'(lat), 32'd3);
        mem_ref[2][4] = wd1;
        s_awaddr  = BASE | 32'h0000_2014; s_wdata = wd2;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        checkOutput("arb2_arready", 32'(s_arready), 32'd1);
        checkOutput("arb2_awready", 32'(s_awready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        s_arvalid = 1'b0;
        wait_resp(1'b0, 0, mem_ref[1][2], lat, rd, errp);
        checkOutput("arb2_latency", 32'(lat), 32'd3);
        checkOutput("arb2_rdata", rd, mem_ref[1][2]);
        #1;
        checkOutput("arb3_awready", 32'(s_awready && s_wready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_resp(1'b1, 0, 32'd0, lat, rd, errp);
        checkOutput("arb3_latency", 32'(lat), 32'd3);
        mem_ref[2][5] = wd2;
        run_txn(1'b0, 2, 4, 32'd0, 0, 1'b0, 1'b0, 0);
        run_txn(1'b0, 2, 5, 32'd0, 1, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
